// File: rtl/peak_scan_ctrl_pkg.sv
// Shared widths, state encoding and result-word layout for the peak scan controller.
// Result word layout (MSB..LSB): {peak1, index1, peak2, index2}.
package peak_scan_ctrl_pkg;

    localparam int unsigned DEF_NUM_CH       = 4;
    localparam int unsigned DEF_VALUE_WIDTH  = 16;
    localparam int unsigned DEF_INDEX_WIDTH  = 12;
    localparam int unsigned DEF_FLUSH_BEATS  = 5;
    localparam int unsigned DEF_CLEAR_CYCLES = 2;
    localparam int unsigned TIMEOUT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SCAN    = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_READOUT = 3'd4
    } scan_state_e;

    // Channel-select width; a single channel still gets one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned word_width(input int unsigned vw, input int unsigned iw);
        return 2 * vw + 2 * iw;
    endfunction

    localparam int unsigned IDX2_LSB = 0;

    function automatic int unsigned peak2_lsb(input int unsigned iw);
        return iw;
    endfunction

    function automatic int unsigned idx1_lsb(input int unsigned vw, input int unsigned iw);
        return vw + iw;
    endfunction

    function automatic int unsigned peak1_lsb(input int unsigned vw, input int unsigned iw);
        return vw + 2 * iw;
    endfunction

endpackage

// File: rtl/peak_result_mux.sv
// Registered NUM_CH:1 result-word serialiser: walks channels 0..NUM_CH-1 over a
// valid/ready stream, holding the word while the consumer stalls.
module peak_result_mux
    import peak_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    localparam int unsigned CH_W       = ch_width(NUM_CH),
    localparam int unsigned WORD_W     = word_width(VALUE_WIDTH, INDEX_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_i,
    input  logic                          ready_i,
    input  logic [NUM_CH*VALUE_WIDTH-1:0] peak1_i,
    input  logic [NUM_CH*VALUE_WIDTH-1:0] peak2_i,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] index1_i,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] index2_i,
    output logic                          valid_o,
    output logic                          last_o,
    output logic [CH_W-1:0]               ch_o,
    output logic [WORD_W-1:0]             data_o,
    output logic                          last_fire_c
);

    localparam int unsigned P1_LSB = peak1_lsb(VALUE_WIDTH, INDEX_WIDTH);
    localparam int unsigned I1_LSB = idx1_lsb(VALUE_WIDTH, INDEX_WIDTH);
    localparam int unsigned P2_LSB = peak2_lsb(INDEX_WIDTH);

    logic [WORD_W-1:0] words [NUM_CH];
    logic              valid_q;
    logic              last_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ch_d;
    logic [WORD_W-1:0] data_q;
    logic              fire_c;

    // Assemble each channel's result word from the detector buses.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_word
        assign words[c][P1_LSB +: VALUE_WIDTH]   = peak1_i[c*VALUE_WIDTH +: VALUE_WIDTH];
        assign words[c][I1_LSB +: INDEX_WIDTH]   = index1_i[c*INDEX_WIDTH +: INDEX_WIDTH];
        assign words[c][P2_LSB +: VALUE_WIDTH]   = peak2_i[c*VALUE_WIDTH +: VALUE_WIDTH];
        assign words[c][IDX2_LSB +: INDEX_WIDTH] = index2_i[c*INDEX_WIDTH +: INDEX_WIDTH];
    end

    assign ch_d        = ch_q + CH_W'(1);
    assign fire_c      = valid_q & ready_i;
    assign last_fire_c = fire_c & last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= (NUM_CH == 1);
            ch_q    <= '0;
            data_q  <= words[0];
        end else if (fire_c) begin
            if (last_q) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                ch_q    <= '0;
            end else begin
                ch_q    <= ch_d;
                data_q  <= words[ch_d];
                last_q  <= (ch_d == CH_W'(NUM_CH - 1));
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign ch_o    = ch_q;
    assign data_o  = data_q;

endmodule

// File: rtl/peak_scan_ctrl.sv
// Frame sequencer for a bank of two-peak detectors: clear, scan, flush, readout.
// Optional build macro PEAK_SCAN_TIMEOUT_EN adds an input-idle timeout in SCAN.
module peak_scan_ctrl
    import peak_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned VALUE_WIDTH  = DEF_VALUE_WIDTH,
    parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned FLUSH_BEATS  = DEF_FLUSH_BEATS,
    parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    localparam int unsigned CH_W        = ch_width(NUM_CH),
    localparam int unsigned WORD_W      = word_width(VALUE_WIDTH, INDEX_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [INDEX_WIDTH-1:0]        frame_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*VALUE_WIDTH-1:0] in_data,
    output logic                          det_aresetn,
    output logic                          det_valid,
    output logic                          det_last,
    output logic [INDEX_WIDTH-1:0]        det_index,
    output logic [NUM_CH*VALUE_WIDTH-1:0] det_data,
    input  logic [NUM_CH*VALUE_WIDTH-1:0] res_peak1,
    input  logic [NUM_CH*VALUE_WIDTH-1:0] res_peak2,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] res_index1,
    input  logic [NUM_CH*INDEX_WIDTH-1:0] res_index2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
`ifdef PEAK_SCAN_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    localparam int unsigned CLR_W   = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned FLUSH_W = $clog2(FLUSH_BEATS + 1);

    scan_state_e            state_q;
    logic                   aresetn_q;
    logic                   done_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [INDEX_WIDTH-1:0] idx_d;
    logic [INDEX_WIDTH-1:0] last_idx_q;
    logic [CLR_W-1:0]       clr_cnt_q;
    logic [FLUSH_W-1:0]     flush_cnt_q;
    logic                   scan_beat_c;
    logic                   scan_end_c;
    logic                   flush_end_c;
    logic                   load_c;
    logic                   word_done_c;
    logic                   scan_timeout_c;

    assign idx_d       = idx_q + INDEX_WIDTH'(1);
    assign scan_beat_c = (state_q == ST_SCAN) && in_valid;
    assign scan_end_c  = scan_beat_c && (idx_q == last_idx_q);
    assign flush_end_c = (flush_cnt_q == FLUSH_W'(FLUSH_BEATS - 1));
    assign load_c      = (state_q == ST_FLUSH) && flush_end_c;

`ifdef PEAK_SCAN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_q;
    logic [TIMEOUT_W-1:0] idle_d;
    logic                 timeout_q;

    assign idle_d         = idle_q + TIMEOUT_W'(1);
    assign scan_timeout_c = (state_q == ST_SCAN) && !in_valid && (idle_d == '1);

    // Idle counter restarts on every accepted beat; timeout flag is sticky per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_SCAN) begin
            if (in_valid) begin
                idle_q <= '0;
            end else if (scan_timeout_c) begin
                timeout_q <= 1'b1;
            end else begin
                idle_q <= idle_d;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign scan_timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            aresetn_q   <= 1'b1;
            done_q      <= 1'b0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            clr_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CLEAR;
                        aresetn_q  <= 1'b0;
                        clr_cnt_q  <= '0;
                        idx_q      <= '0;
                        // A zero length is run as a single-sample frame.
                        last_idx_q <= (frame_len == '0) ? '0 : frame_len - INDEX_WIDTH'(1);
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                        state_q   <= ST_SCAN;
                        aresetn_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + CLR_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (scan_beat_c) begin
                        idx_q <= idx_d;
                    end
                    if (scan_end_c || scan_timeout_c) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    idx_q <= idx_d;
                    if (flush_end_c) begin
                        state_q <= ST_READOUT;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
                    end
                end
                ST_READOUT: begin
                    if (word_done_c) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Detector strobes: real samples pass through in SCAN, zero padding in FLUSH.
    assign det_aresetn = aresetn_q;
    assign in_ready    = (state_q == ST_SCAN);
    assign det_valid   = scan_beat_c || (state_q == ST_FLUSH);
    assign det_last    = scan_end_c;
    assign det_index   = idx_q;
    assign det_data    = (state_q == ST_SCAN) ? in_data : '0;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

    peak_result_mux #(
        .NUM_CH      (NUM_CH),
        .VALUE_WIDTH (VALUE_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_result_mux (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_c),
        .ready_i     (out_ready),
        .peak1_i     (res_peak1),
        .peak2_i     (res_peak2),
        .index1_i    (res_index1),
        .index2_i    (res_index2),
        .valid_o     (out_valid),
        .last_o      (out_last),
        .ch_o        (out_ch),
        .data_o      (out_data),
        .last_fire_c (word_done_c)
    );

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl: frame sequencing, gapped input, readout
// back-pressure, ignored start, mid-frame reset, and the optional timeout.
module tb_peak_scan_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned VW  = 16;
    localparam int unsigned IW  = 12;
    localparam int unsigned CHW = 2;
    localparam int unsigned WW  = 2 * VW + 2 * IW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [IW-1:0]     frame_len;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*VW-1:0] in_data;
    logic              det_aresetn;
    logic              det_valid;
    logic              det_last;
    logic [IW-1:0]     det_index;
    logic [NCH*VW-1:0] det_data;
    logic [NCH*VW-1:0] res_peak1;
    logic [NCH*VW-1:0] res_peak2;
    logic [NCH*IW-1:0] res_index1;
    logic [NCH*IW-1:0] res_index2;
    logic              out_valid;
    logic              out_ready;
    logic [WW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef PEAK_SCAN_TIMEOUT_EN
    logic              timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peak_scan_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .det_aresetn (det_aresetn),
        .det_valid   (det_valid),
        .det_last    (det_last),
        .det_index   (det_index),
        .det_data    (det_data),
        .res_peak1   (res_peak1),
        .res_peak2   (res_peak2),
        .res_index1  (res_index1),
        .res_index2  (res_index2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .busy        (busy),
`ifdef PEAK_SCAN_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic s, input logic v, input logic [63:0] d, input logic r);
        @(negedge clk);
        start     = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    function automatic logic [63:0] dat(input int k);
        return 64'h1111_2222_3333_4440 + 64'(k);
    endfunction

    function automatic logic [WW-1:0] exp_word(input int c);
        return {res_peak1[c*VW +: VW], res_index1[c*IW +: IW],
                res_peak2[c*VW +: VW], res_index2[c*IW +: IW]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_aresetn"}, 64'(det_aresetn), 64'd1);
        chk({tag, "_det_valid"}, 64'(det_valid), 64'd0);
        chk({tag, "_det_last"}, 64'(det_last), 64'd0);
        chk({tag, "_det_index"}, 64'(det_index), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_ch"}, 64'(out_ch), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // One-sample frame with an uninterrupted readout.
    task automatic short_frame(input logic [IW-1:0] len, input string tag);
        frame_len = len;
        drive(1'b1, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk({tag, "_clr0"}, 64'(det_aresetn), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk({tag, "_clr1"}, 64'(det_aresetn), 64'd0);
        drive(1'b0, 1'b1, dat(20), 1'b1);
        chk({tag, "_beat_idx"}, 64'(det_index), 64'd0);
        chk({tag, "_beat_last"}, 64'(det_last), 64'd1);
        chk({tag, "_beat_aresetn"}, 64'(det_aresetn), 64'd1);
        for (int f = 0; f < 5; f++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk({tag, "_flush_valid"}, 64'(det_valid), 64'd1);
            chk({tag, "_flush_idx"}, 64'(det_index), 64'(f + 1));
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk({tag, "_rd_ch"}, 64'(out_ch), 64'(c));
            chk({tag, "_rd_last"}, 64'(out_last), 64'(c == 3));
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            res_peak1[c*VW +: VW]  = 16'h1000 + 16'(c * 16'h0111);
            res_index1[c*IW +: IW] = 12'h100 + 12'(c);
            res_peak2[c*VW +: VW]  = 16'h0800 + 16'(c * 16'h0022);
            res_index2[c*IW +: IW] = 12'h200 + 12'(c * 3);
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
`ifdef PEAK_SCAN_TIMEOUT_EN
        chk("rst_timeout", 64'(timeout), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Frame A: 8 continuous beats, stray start mid-scan, readout with back-pressure
        frame_len = 12'd8;
        drive(1'b1, 1'b0, '0, 1'b0);
        chk("a_idle_busy", 64'(busy), 64'd0);
        chk("a_idle_aresetn", 64'(det_aresetn), 64'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("a_clr0_aresetn", 64'(det_aresetn), 64'd0);
        chk("a_clr0_busy", 64'(busy), 64'd1);
        chk("a_clr0_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("a_clr1_aresetn", 64'(det_aresetn), 64'd0);
        for (int k = 0; k < 8; k++) begin
            frame_len = (k == 4) ? 12'd3 : 12'd8;
            drive(k == 4, 1'b1, dat(k), 1'b0);
            chk("a_scan_in_ready", 64'(in_ready), 64'd1);
            chk("a_scan_aresetn", 64'(det_aresetn), 64'd1);
            chk("a_scan_valid", 64'(det_valid), 64'd1);
            chk("a_scan_idx", 64'(det_index), 64'(k));
            chk("a_scan_data", det_data, dat(k));
            chk("a_scan_last", 64'(det_last), 64'(k == 7));
        end
        frame_len = 12'd8;
        for (int f = 0; f < 5; f++) begin
            drive(1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
            chk("a_flush_valid", 64'(det_valid), 64'd1);
            chk("a_flush_data", det_data, 64'd0);
            chk("a_flush_idx", 64'(det_index), 64'(8 + f));
            chk("a_flush_last", 64'(det_last), 64'd0);
            chk("a_flush_in_ready", 64'(in_ready), 64'd0);
        end
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 1'b0, '0, 1'b0);
            chk("a_stall_valid", 64'(out_valid), 64'd1);
            chk("a_stall_ch", 64'(out_ch), 64'(c));
            chk("a_stall_data", 64'(out_data), 64'(exp_word(c)));
            chk("a_stall_last", 64'(out_last), 64'(c == 3));
            chk("a_stall_det_valid", 64'(det_valid), 64'd0);
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("a_hs_ch", 64'(out_ch), 64'(c));
            chk("a_hs_data", 64'(out_data), 64'(exp_word(c)));
            chk("a_hs_done", 64'(done), 64'd0);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("a_done", 64'(done), 64'd1);
        chk("a_done_busy", 64'(busy), 64'd0);
        chk("a_done_out_valid", 64'(out_valid), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("a_done_pulse", 64'(done), 64'd0);

        // Frame B: gapped input, 4 samples
        frame_len = 12'd4;
        drive(1'b1, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("b_clr0", 64'(det_aresetn), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("b_clr1", 64'(det_aresetn), 64'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, (i % 2) == 0, dat(16 + i), 1'b1);
            chk("b_scan_valid", 64'(det_valid), 64'((i % 2) == 0));
            chk("b_scan_idx", 64'(det_index), 64'((i + 1) / 2));
            chk("b_scan_last", 64'(det_last), 64'(i == 6));
        end
        for (int f = 0; f < 5; f++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("b_flush_idx", 64'(det_index), 64'(4 + f));
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("b_rd_ch", 64'(out_ch), 64'(c));
            chk("b_rd_data", 64'(out_data), 64'(exp_word(c)));
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("b_done", 64'(done), 64'd1);

        // Frame C: reset at beat 3 of 8, then a fresh single-sample frame
        frame_len = 12'd8;
        drive(1'b1, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, dat(k), 1'b1);
            chk("c_scan_idx", 64'(det_index), 64'(k));
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, dat(4), 1'b1);
        check_reset_outputs("c_abort");
        reset = 1'b0;
        short_frame(12'd1, "d_len1");
        short_frame(12'd0, "e_len0");

`ifdef PEAK_SCAN_TIMEOUT_EN
        // Stall after 2 of 8 beats until the idle timeout forces FLUSH
        begin
            int n;
            frame_len = 12'd8;
            drive(1'b1, 1'b0, '0, 1'b1);
            drive(1'b0, 1'b0, '0, 1'b1);
            drive(1'b0, 1'b0, '0, 1'b1);
            drive(1'b0, 1'b1, dat(0), 1'b1);
            drive(1'b0, 1'b1, dat(1), 1'b1);
            n = 0;
            for (int i = 0; i < 70000; i++) begin
                drive(1'b0, 1'b0, '0, 1'b1);
                if (det_valid) break;
                n++;
            end
            chk("t_idle_cycles", 64'(n), 64'd65535);
            chk("t_timeout", 64'(timeout), 64'd1);
            chk("t_flush_idx", 64'(det_index), 64'd2);
            chk("t_flush_data", det_data, 64'd0);
            repeat (4) drive(1'b0, 1'b0, '0, 1'b1);
            for (int c = 0; c < 4; c++) begin
                drive(1'b0, 1'b0, '0, 1'b1);
                chk("t_rd_ch", 64'(out_ch), 64'(c));
            end
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("t_done", 64'(done), 64'd1);
            chk("t_timeout_sticky", 64'(timeout), 64'd1);
            frame_len = 12'd1;
            drive(1'b1, 1'b0, '0, 1'b1);
            drive(1'b0, 1'b0, '0, 1'b1);
            chk("t_timeout_clr", 64'(timeout), 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_scan_ctrl.md
Name: peak_scan_ctrl

Overview:
Sequences one scan frame through a bank of NUM_CH two-peak detector channels: it clears them, streams samples with generated index/valid/last, flushes their internal delay line, then serialises every channel's result over a valid/ready output stream. It sits between the ADC sample stream and the per-channel peak detectors, and owns their reset and strobe signals.

Parameters:
NUM_CH, 4, number of detector channels driven in lockstep
VALUE_WIDTH, 16, sample/peak width (matches constants include)
INDEX_WIDTH, 12, bin index width
FLUSH_BEATS, 5, zero-padded valid beats after last sample (detector index lag)
CLEAR_CYCLES, 2, cycles det_aresetn held low before scan

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
start  in  1  begin frame (sampled in IDLE only)
frame_len  in  INDEX_WIDTH  samples per frame, captured at start; 0 treated as 1
in_valid  in  1  sample beat valid
in_ready  out  1  high only in SCAN
in_data  in  NUM_CH*VALUE_WIDTH  one sample per channel
det_aresetn  out  1  detector reset, active-low
det_valid  out  1  detector beat strobe
det_last  out  1  final real sample of frame
det_index  out  INDEX_WIDTH  bin index of current beat
det_data  out  NUM_CH*VALUE_WIDTH  in_data in SCAN, zeros in FLUSH
res_peak1, res_peak2  in  NUM_CH*VALUE_WIDTH  detector peaks
res_index1, res_index2  in  NUM_CH*INDEX_WIDTH  detector indices
out_valid  out  1  result word valid
out_ready  in  1  consumer ready
out_data  out  2*VALUE_WIDTH+2*INDEX_WIDTH  {peak1,index1,peak2,index2} of out_ch
out_ch  out  clog2(NUM_CH)  channel of out_data
out_last  out  1  high with final channel word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on final readout handshake

Behaviour:
- Reset: state IDLE, det_aresetn=1, det_valid=0, det_last=0, det_index=0, in_ready=0, out_valid=0, out_ch=0, out_last=0, busy=0, done=0. Reset mid-frame aborts immediately; the next start re-clears the detectors.
- IDLE -> CLEAR on start; latch frame_len.
- CLEAR: det_aresetn=0 for CLEAR_CYCLES, then SCAN with index counter=0.
- SCAN: in_ready=1; on each in_valid, det_valid=1 (combinational from in_valid), det_data=in_data, det_index=counter, counter++. The beat with counter==len-1 asserts det_last, then -> FLUSH.
- FLUSH: det_valid=1 every cycle for FLUSH_BEATS cycles, det_data=0, det_index continues incrementing (wraps mod 2^INDEX_WIDTH), det_last=0; then -> READOUT.
- READOUT: registered out_valid=1, out_ch steps 0..NUM_CH-1; advance only on out_valid&&out_ready; out_data is stable while stalled. Handshake on NUM_CH-1: out_last=1 with that word, done pulses next cycle, -> IDLE.
- start outside IDLE ignored. in_valid outside SCAN ignored (in_ready=0).
- frame_len=1: single beat carries det_last.

Optional Feature:
PEAK_SCAN_TIMEOUT_EN: with the macro, SCAN contains a 16-bit idle counter reset on each in_valid; reaching 0xFFFF forces FLUSH, and sticky output timeout (cleared at next start) is set. Without it, SCAN waits indefinitely and the timeout port is absent.

Decomposition:
- Shared package/include: VALUE_WIDTH, INDEX_WIDTH, NUM_CH, state encoding (IDLE, CLEAR, SCAN, FLUSH, READOUT), result-word field offsets.
- One sub-module: peak_result_mux (registered NUM_CH:1 selection of the result word by out_ch, with ready hold).

Test Plan:
- reset, start, frame_len=8, 8 continuous beats -> det_aresetn low 2 cycles; det_index 0..7; det_last on index 7; then 5 zero beats, index 8..12.
- in_valid gapped every other cycle, frame_len=4 -> det_valid only on accepted beats; index has no gaps.
- NUM_CH=4, results preset per channel, out_ready toggled 1/0 -> 4 words, ch 0..3, data stable while stalled, out_last on ch3, done one cycle after.
- start pulsed during SCAN/READOUT -> ignored; frame completes unchanged.
- reset asserted at beat 3 of 8 -> all outputs return to reset values next cycle; new start gives a clean CLEAR.
- PEAK_SCAN_TIMEOUT_EN, stall after 2 of 8 beats -> FLUSH after 65535 idle cycles, timeout=1, readout proceeds.
